// File: rtl/data_mem_arbiter.sv
// Two-master round-robin arbiter in front of the single-port word data memory.
// Optional statistics counters are enabled with the DATA_MEM_ARB_STATS_EN macro.
module data_mem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic [DATA_W-1:0] rdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata1,
    output logic              ack1,
    output logic              memWrite,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] writeData,
    input  logic [DATA_W-1:0] readData
`ifdef DATA_MEM_ARB_STATS_EN
    ,
    output logic [15:0]       waitCnt0,
    output logic [15:0]       waitCnt1,
    output logic [15:0]       grantSwitches
`endif
);

    localparam int unsigned HOLD_W = 4;
    localparam int unsigned STAT_W = 16;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0]        state, state_n;
    logic              last_owner, last_owner_n;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
    logic [HOLD_W:0]   hold_nxt;
    logic              own1, own_req, oth_req;
    logic [1:0]        oth_state;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            hold_cnt   <= '0;
        end else begin
            state      <= state_n;
            last_owner <= last_owner_n;
            hold_cnt   <= hold_cnt_n;
        end
    end

    // Grant decision and access routing
    always_comb begin
        state_n      = state;
        last_owner_n = last_owner;
        hold_cnt_n   = hold_cnt;
        hold_nxt     = (HOLD_W+1)'(hold_cnt) + (HOLD_W+1)'(1);
        own1         = 1'b0;
        own_req      = 1'b0;
        oth_req      = 1'b0;
        oth_state    = IDLE;
        ack0         = 1'b0;
        ack1         = 1'b0;
        rdata0       = '0;
        rdata1       = '0;
        memWrite     = 1'b0;
        addr         = '0;
        writeData    = '0;

        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_n = last_owner ? OWN0 : OWN1;
                end else if (req0) begin
                    state_n = OWN0;
                end else if (req1) begin
                    state_n = OWN1;
                end
            end
            OWN0, OWN1: begin
                own1      = (state == OWN1);
                own_req   = own1 ? req1 : req0;
                oth_req   = own1 ? req0 : req1;
                oth_state = own1 ? OWN0 : OWN1;
                if (own_req) begin
                    if (own1) begin
                        ack1      = 1'b1;
                        addr      = addr1;
                        memWrite  = we1;
                        writeData = wdata1;
                        rdata1    = readData;
                    end else begin
                        ack0      = 1'b1;
                        addr      = addr0;
                        memWrite  = we0;
                        writeData = wdata0;
                        rdata0    = readData;
                    end
                    // Hold counter keeps counting while uncontended so a late rival is not starved
                    if (!oth_req) begin
                        hold_cnt_n = (hold_nxt >= (HOLD_W+1)'(MAX_HOLD)) ? HOLD_W'(MAX_HOLD)
                                                                          : hold_nxt[HOLD_W-1:0];
                    end else if (hold_nxt < (HOLD_W+1)'(MAX_HOLD)) begin
                        hold_cnt_n = hold_nxt[HOLD_W-1:0];
                    end else begin
                        state_n      = oth_state;
                        hold_cnt_n   = '0;
                        last_owner_n = own1;
                    end
                end else if (oth_req) begin
                    state_n      = oth_state;
                    hold_cnt_n   = '0;
                    last_owner_n = own1;
                end else begin
                    state_n      = IDLE;
                    hold_cnt_n   = '0;
                    last_owner_n = own1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

`ifdef DATA_MEM_ARB_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic owner_swap;
    assign owner_swap = ((state == OWN0) && (state_n == OWN1)) ||
                        ((state == OWN1) && (state_n == OWN0));

    // Saturating wait and owner-switch counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waitCnt0      <= '0;
            waitCnt1      <= '0;
            grantSwitches <= '0;
        end else begin
            if (req0 && !ack0 && (waitCnt0 != STAT_MAX)) begin
                waitCnt0 <= waitCnt0 + STAT_W'(1);
            end
            if (req1 && !ack1 && (waitCnt1 != STAT_MAX)) begin
                waitCnt1 <= waitCnt1 + STAT_W'(1);
            end
            if (owner_swap && (grantSwitches != STAT_MAX)) begin
                grantSwitches <= grantSwitches + STAT_W'(1);
            end
        end
    end
`endif

endmodule
